jtag_shift_master: RTL and testbench

//  Simulation-side JTAG bit-bang master that drives TCK/TMS/TDI into the FPGA JTAG sim pin stage and samples TDO.

---
 rtl/jtag_master_pkg.sv | 32 +++
 rtl/jtag_shift_master_if.sv | 31 +++
 rtl/jtag_tck_gen.sv | 34 +++
 rtl/jtag_shift_master.sv | 179 +++++++++++++++++
 tb/tb_jtag_shift_master.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_master_pkg.sv
// Shared types and TAP navigation constants for the JTAG shift master.
package jtag_master_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } jm_state_e;

  localparam int unsigned SEQ_W      = 3;
  localparam int unsigned TLR_TCKS   = 5;
  localparam int unsigned DR_PRE_LEN = 3;
  localparam int unsigned IR_PRE_LEN = 4;
  localparam int unsigned POST_LEN   = 2;

  // TMS sequences, bit 0 goes out first.
  localparam logic [3:0] DR_PRE_TMS = 4'b0001;  // 1,0,0   Idle -> Shift-DR
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;  // 1,1,0,0 Idle -> Shift-IR
  localparam logic [1:0] POST_TMS   = 2'b01;    // 1,0     Exit1 -> Update -> Idle

  function automatic logic pre_tms(input logic ir, input logic [1:0] idx);
    return ir ? IR_PRE_TMS[idx] : DR_PRE_TMS[idx];
  endfunction

  function automatic logic [SEQ_W-1:0] pre_last(input logic ir);
    return ir ? SEQ_W'(IR_PRE_LEN - 1) : SEQ_W'(DR_PRE_LEN - 1);
  endfunction

endpackage

// File: rtl/jtag_shift_master_if.sv
// Command/response bus of jtag_shift_master; cmd_tlr exists only with JTAG_MASTER_TLR_CMD_EN.
interface jtag_shift_master_if #(
  parameter int unsigned MAX_LEN = 32,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_ir;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
`ifdef JTAG_MASTER_TLR_CMD_EN
  logic               cmd_tlr;
`endif
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

`ifdef JTAG_MASTER_TLR_CMD_EN
  modport master (output cmd_valid, cmd_ir, cmd_len, cmd_data, cmd_tlr, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, busy);
  modport slave  (input  cmd_valid, cmd_ir, cmd_len, cmd_data, cmd_tlr, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, busy);
`else
  modport master (output cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, busy);
  modport slave  (input  cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, busy);
`endif

endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: half-period of TCK_DIV clk cycles, low half first, parked low while en=0.
module jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             toggle;

  // Strobes are high in the cycle whose closing edge flips tck.
  assign toggle   = en && (cnt_q == CNT_W'(TCK_DIV - 1));
  assign rise_stb = toggle && !tck;
  assign fall_stb = toggle && tck;

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      cnt_q <= '0;
      tck   <= 1'b0;
    end else if (toggle) begin
      cnt_q <= '0;
      tck   <= ~tck;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG bit-bang master: walks the TAP from Run-Test/Idle through one IR/DR shift and back.
// Optional macro JTAG_MASTER_TLR_CMD_EN adds a TAP-reset command (cmd_tlr).
module jtag_shift_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TCK_DIV = 2,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  jtag_shift_master_if.slave   bus,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);

  jm_state_e          state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d, seq_nxt;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ir_q, ir_d;
  logic               tlr_q, tlr_d;
  logic [MAX_LEN-1:0] data_q, data_d, data_shr;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               tck_en, fall_stb, rise_stb;

  assign tck_en   = (state_q == INIT) || (state_q == PRE) ||
                    (state_q == SHIFT) || (state_q == POST);
  assign seq_nxt  = seq_q + SEQ_W'(1);
  assign data_shr = data_q >> 1;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INIT;
      seq_q   <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      tlr_q   <= 1'b0;
      data_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      tlr_q   <= tlr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // Each TCK's tms/tdi is set at the falling edge that ends the previous TCK;
  // the first TCK after IDLE gets its value at accept, while tck is parked low.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    bit_d   = bit_q;
    len_d   = len_q;
    ir_d    = ir_q;
    tlr_d   = tlr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    unique case (state_q)
      INIT: begin
        if (fall_stb) begin
          if (seq_q == SEQ_W'(TLR_TCKS)) begin
            state_d = tlr_q ? RESP : IDLE;
            seq_d   = '0;
            tlr_d   = 1'b0;
          end else begin
            seq_d = seq_nxt;
            tms_d = (seq_q != SEQ_W'(TLR_TCKS - 1));
          end
        end
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          rsp_d = '0;
          seq_d = '0;
          bit_d = '0;
`ifdef JTAG_MASTER_TLR_CMD_EN
          if (bus.cmd_tlr) begin
            tlr_d   = 1'b1;
            tms_d   = 1'b1;
            state_d = INIT;
          end else
`endif
          if (bus.cmd_len == '0) begin
            state_d = RESP;
          end else begin
            ir_d    = bus.cmd_ir;
            len_d   = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
            data_d  = bus.cmd_data;
            tms_d   = 1'b1;
            state_d = PRE;
          end
        end
      end
      PRE: begin
        if (fall_stb) begin
          if (seq_q == pre_last(ir_q)) begin
            state_d = SHIFT;
            seq_d   = '0;
            bit_d   = '0;
            tdi_d   = data_q[0];
            tms_d   = (len_q == LEN_W'(1));
          end else begin
            seq_d = seq_nxt;
            tms_d = pre_tms(ir_q, seq_nxt[1:0]);
          end
        end
      end
      SHIFT: begin
        if (rise_stb) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (bit_q == LEN_W'(i)) rsp_d[i] = tdo;
          end
        end
        if (fall_stb) begin
          if (bit_q == len_q - LEN_W'(1)) begin
            state_d = POST;
            seq_d   = '0;
            tms_d   = POST_TMS[0];
            tdi_d   = 1'b0;
          end else begin
            bit_d  = bit_q + LEN_W'(1);
            data_d = data_shr;
            tdi_d  = data_shr[0];
            tms_d  = (bit_q + LEN_W'(1) == len_q - LEN_W'(1));
          end
        end
      end
      POST: begin
        if (fall_stb) begin
          if (seq_q == SEQ_W'(POST_LEN - 1)) begin
            state_d = RESP;
            seq_d   = '0;
          end else begin
            seq_d = seq_nxt;
            tms_d = POST_TMS[seq_nxt[0]];
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE) && (state_q != RESP);
  assign bus.rsp_data  = rsp_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master: vector table of shifts plus reset/hold/abort sequences.
module tb_jtag_shift_master;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned TCK_DIV = 2;
  localparam int unsigned TR_SZ   = 4096;

  typedef struct {
    logic        ir;
    logic [5:0]  len;
    logic [31:0] data;
    logic        direct;
    logic [31:0] exp_rsp;
    int unsigned exp_tcks;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tck, tms, tdi, tdo;

  always #5 clk = ~clk;

  jtag_shift_master_if #(.MAX_LEN(MAX_LEN)) bus();

  jtag_shift_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo)
  );

  // TDO source: tdi directly, or tdi delayed by one TCK (captured on rise, driven on fall).
  logic tdo_direct = 1'b1;
  logic tdo_d1 = 1'b0;
  logic tdo_dly = 1'b0;
  always @(posedge tck) tdo_d1 <= tdi;
  always @(negedge tck) tdo_dly <= tdo_d1;
  assign tdo = tdo_direct ? tdi : tdo_dly;

  int unsigned cyc = 0;
  int unsigned rise_cnt = 0;
  logic        tms_tr [TR_SZ];
  logic        tdi_tr [TR_SZ];
  int unsigned rise_cyc [TR_SZ];

  always @(negedge clk) cyc = cyc + 1;

  always @(posedge tck) begin
    if (rise_cnt < TR_SZ) begin
      tms_tr[rise_cnt]   = tms;
      tdi_tr[rise_cnt]   = tdi;
      rise_cyc[rise_cnt] = cyc;
    end
    rise_cnt = rise_cnt + 1;
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_rises(input int unsigned target, input string name);
    int unsigned w = 0;
    while (rise_cnt < target && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (rise_cnt < target) timeout(name);
  endtask

  task automatic wait_ready(input string name);
    int unsigned w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (bus.cmd_ready !== 1'b1) timeout(name);
  endtask

  function automatic logic [63:0] get_tms(input int unsigned base, input int unsigned n);
    logic [63:0] v = '0;
    for (int unsigned i = 0; i < n && i < 64; i++)
      if (base + i < TR_SZ) v[i] = tms_tr[base + i];
    return v;
  endfunction

  function automatic logic [63:0] get_tdi(input int unsigned base, input int unsigned n);
    logic [63:0] v = '0;
    for (int unsigned i = 0; i < n && i < 64; i++)
      if (base + i < TR_SZ) v[i] = tdi_tr[base + i];
    return v;
  endfunction

  // Expected TMS at each TCK rise of an IR/DR shift of n bits.
  function automatic logic [63:0] model_tms(input logic ir, input int unsigned n);
    logic [63:0] v = '0;
    int unsigned p = ir ? 4 : 3;
    v[0] = 1'b1;
    if (ir) v[1] = 1'b1;
    if (n > 0) begin
      v[p + n - 1] = 1'b1;
      v[p + n]     = 1'b1;
    end
    return v;
  endfunction

  task automatic run_cmd(input logic ir, input logic [5:0] len, input logic [31:0] data,
                         input logic tlr, output int unsigned lat, output int unsigned base);
    @(negedge clk);
    bus.cmd_ir    = ir;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
`ifdef JTAG_MASTER_TLR_CMD_EN
    bus.cmd_tlr   = tlr;
`else
    if (tlr) $display("note: tlr request ignored in this build");
`endif
    bus.cmd_valid = 1'b1;
    wait_ready("cmd_accept");
    base = rise_cnt;
    lat  = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.cmd_valid = 1'b0;
    end while (bus.rsp_valid !== 1'b1 && lat < 2000);
    if (bus.rsp_valid !== 1'b1) timeout("rsp_valid");
  endtask

  task automatic handshake;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_init_seq(input string tag);
    int unsigned base = rise_cnt;
    wait_rises(base + 6, {tag, "_rises"});
    wait_ready({tag, "_ready"});
    chk({tag, "_tms_trace"}, get_tms(base, 6), 64'h1F);
    chk({tag, "_tck_count"}, 64'(rise_cnt - base), 64'd6);
    chk({tag, "_tck_period"}, 64'(rise_cyc[base + 1] - rise_cyc[base]), 64'(2 * TCK_DIV));
    chk({tag, "_idle_tck_busy"}, {62'b0, tck, bus.busy}, 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    int unsigned lat, base, n, p, exp_lat, errs;
    logic [63:0] mask;

    vecs[0] = '{1'b0, 6'd8,  32'h0000_00A5, 1'b1, 32'h0000_00A5, 13};
    vecs[1] = '{1'b1, 6'd6,  32'h0000_0009, 1'b0, 32'h0000_0012, 12};
    vecs[2] = '{1'b0, 6'd1,  32'h0000_0001, 1'b1, 32'h0000_0001, 6};
    vecs[3] = '{1'b0, 6'd32, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 37};
    vecs[4] = '{1'b0, 6'd40, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 37};
    vecs[5] = '{1'b1, 6'd0,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 0};
    vecs[6] = '{1'b0, 6'd4,  32'hFFFF_FFF3, 1'b1, 32'h0000_0003, 9};
    vecs[7] = '{1'b1, 6'd3,  32'h0000_0005, 1'b0, 32'h0000_0002, 9};

    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
`ifdef JTAG_MASTER_TLR_CMD_EN
    bus.cmd_tlr   = 1'b0;
`endif

    // Reset values and INIT sequence.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins_tck_tms_tdi", {61'b0, tck, tms, tdi}, 64'b010);
    chk("reset_ready_valid_busy", {61'b0, bus.cmd_ready, bus.rsp_valid, bus.busy}, 64'b001);
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check_init_seq("init");

    // Table-driven shifts.
    for (int unsigned k = 0; k < 8; k++) begin
      tdo_direct = vecs[k].direct;
      run_cmd(vecs[k].ir, vecs[k].len, vecs[k].data, 1'b0, lat, base);
      n = (vecs[k].len > 6'd32) ? 32 : int'(vecs[k].len);
      p = vecs[k].ir ? 4 : 3;
      mask = (n >= 32) ? 64'hFFFF_FFFF : ((64'd1 << n) - 64'd1);
      chk($sformatf("v%0d_rsp_data", k), 64'(bus.rsp_data), 64'(vecs[k].exp_rsp));
      chk($sformatf("v%0d_tck_count", k), 64'(rise_cnt - base), 64'(vecs[k].exp_tcks));
      if (vecs[k].exp_tcks > 0) begin
        chk($sformatf("v%0d_tms_trace", k), get_tms(base, vecs[k].exp_tcks),
            model_tms(vecs[k].ir, n));
        chk($sformatf("v%0d_tdi_trace", k), get_tdi(base + p, n),
            64'(vecs[k].data) & mask);
      end
      exp_lat = (vecs[k].exp_tcks == 0) ? 1 : 4 * vecs[k].exp_tcks + 1;
      n_vec++;
      if (lat + 1 < exp_lat || lat > exp_lat + 1) begin
        n_bad++;
        $display("FAIL v%0d_latency: got %0d want %0d (+-1)", k, lat, exp_lat);
      end
      handshake();
    end

    // Response held: must stay stable and block new commands.
    tdo_direct = 1'b1;
    run_cmd(1'b0, 6'd8, 32'h3C, 1'b0, lat, base);
    bus.cmd_len   = 6'd4;
    bus.cmd_data  = 32'hF;
    bus.cmd_valid = 1'b1;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h3C || bus.cmd_ready !== 1'b0) errs++;
    end
    chk("hold_stable_cycles_bad", 64'(errs), 64'd0);
    chk("hold_no_tck", 64'(rise_cnt - base), 64'd13);
    bus.cmd_valid = 1'b0;
    handshake();
    chk("after_hs_ready_valid", {62'b0, bus.cmd_ready, bus.rsp_valid}, 64'b10);
    run_cmd(1'b0, 6'd4, 32'h6, 1'b0, lat, base);
    chk("after_hs_rsp_data", 64'(bus.rsp_data), 64'h6);
    handshake();

    // Reset during SHIFT bit 3 (7th TCK rise of a DR shift).
    @(negedge clk);
    bus.cmd_ir = 1'b0; bus.cmd_len = 6'd8; bus.cmd_data = 32'hFF; bus.cmd_valid = 1'b1;
    wait_ready("abort_accept");
    base = rise_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_rises(base + 7, "abort_bit3");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tck_tms_valid", {61'b0, tck, tms, bus.rsp_valid}, 64'b010);
    chk("abort_busy_data", {31'b0, bus.busy, bus.rsp_data}, {31'b0, 1'b1, 32'h0});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_init_seq("reinit");

`ifdef JTAG_MASTER_TLR_CMD_EN
    run_cmd(1'b1, 6'd8, 32'hFF, 1'b1, lat, base);
    chk("tlr_tck_count", 64'(rise_cnt - base), 64'd6);
    chk("tlr_tms_trace", get_tms(base, 6), 64'h1F);
    chk("tlr_rsp_data", 64'(bus.rsp_data), 64'd0);
    handshake();
    bus.cmd_tlr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
